// File: rtl/nabp_angle_sequencer_if.sv
// Host handshake between the angle sequencer and the swap controller's host port.
// The sequencer drives angles (master); the swap controller requests them (slave).
interface nabp_angle_sequencer_if #(
  parameter int kAngleLength = 8
) ();
  logic [kAngleLength-1:0] hs_angle;
  logic                    hs_has_next_angle;
  logic                    hs_next_angle;
  logic                    hs_next_angle_ack;

  modport master (
    output hs_angle,
    output hs_has_next_angle,
    output hs_next_angle_ack,
    input  hs_next_angle
  );

  modport slave (
    input  hs_angle,
    input  hs_has_next_angle,
    input  hs_next_angle_ack,
    output hs_next_angle
  );
endinterface

// File: rtl/nabp_angle_sequencer.sv
// Projection-angle sequencer: latches a (start, step, count) schedule on a start kick,
// hands out one angle per handshake with modulo wrap, then waits for pr_done.
module nabp_angle_sequencer #(
  parameter int kAngleLength = 8,
  parameter int kAngleMax    = 180
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    start,
  input  logic [kAngleLength-1:0] cfg_angle_start,
  input  logic [kAngleLength-1:0] cfg_angle_step,
  input  logic [kAngleLength-1:0] cfg_angle_count,
  input  logic                    pr_done,
  nabp_angle_sequencer_if.master  hs,
  output logic                    busy,
  output logic                    done,
  output logic                    cfg_error,
  output logic [kAngleLength-1:0] issued_count
);

  localparam int w = kAngleLength;
  localparam logic [w:0] angle_max = (w+1)'(kAngleMax);

  typedef enum logic [1:0] {
    idle_s,
    issue_s,
    drain_s,
    done_s
  } state_t;

  state_t         state_q;
  state_t         next_state;
  logic [w-1:0]   angle_q;
  logic [w-1:0]   step_q;
  logic [w-1:0]   remaining_q;
  logic [w-1:0]   issued_q;
  logic           cfg_error_q;
  logic           zero_done_q;

  logic           ack;
  logic           has_next;
  logic           load_cfg;
  logic           advance;
  logic           cfg_error_d;
  logic           zero_done_d;

  // Both operands are below kAngleMax, so a single conditional subtract is a full modulo.
  function automatic logic [w-1:0] wrap_add(input logic [w-1:0] a, input logic [w-1:0] b);
    logic [w:0] sum;
    sum = {1'b0, a} + {1'b0, b};
    if (sum >= angle_max) sum = sum - angle_max;
    return sum[w-1:0];
  endfunction

  function automatic logic cfg_illegal(input logic [w-1:0] first, input logic [w-1:0] step);
    return ({1'b0, first} >= angle_max) || (step == '0) || ({1'b0, step} >= angle_max);
  endfunction

  always_comb begin
    next_state  = state_q;
    ack         = 1'b0;
    has_next    = 1'b0;
    load_cfg    = 1'b0;
    advance     = 1'b0;
    cfg_error_d = 1'b0;
    zero_done_d = 1'b0;
    case (state_q)
      idle_s: begin
        if (start) begin
          if (cfg_illegal(cfg_angle_start, cfg_angle_step)) begin
            cfg_error_d = 1'b1;
          end else if (cfg_angle_count == '0) begin
            zero_done_d = 1'b1;
          end else begin
            load_cfg   = 1'b1;
            next_state = issue_s;
          end
        end
      end
      issue_s: begin
        has_next = 1'b1;
        ack      = hs.hs_next_angle;
        if (ack) begin
          advance = 1'b1;
          if (remaining_q == w'(1)) next_state = drain_s;
        end
      end
      drain_s: begin
        if (pr_done) next_state = done_s;
      end
      done_s: begin
        next_state = idle_s;
      end
      default: begin
        next_state = idle_s;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= idle_s;
      angle_q     <= '0;
      step_q      <= '0;
      remaining_q <= '0;
      issued_q    <= '0;
      cfg_error_q <= 1'b0;
      zero_done_q <= 1'b0;
    end else begin
      state_q     <= next_state;
      cfg_error_q <= cfg_error_d;
      zero_done_q <= zero_done_d;
      if (load_cfg) begin
        angle_q     <= cfg_angle_start;
        step_q      <= cfg_angle_step;
        remaining_q <= cfg_angle_count;
        issued_q    <= '0;
      end else if (advance) begin
        angle_q     <= wrap_add(angle_q, step_q);
        remaining_q <= remaining_q - w'(1);
        issued_q    <= issued_q + w'(1);
      end
    end
  end

  // A zero-count schedule completes from idle, so done has two sources.
  assign hs.hs_angle          = angle_q;
  assign hs.hs_has_next_angle = has_next;
  assign hs.hs_next_angle_ack = ack;
  assign busy                 = (state_q != idle_s);
  assign done                 = (state_q == done_s) || zero_done_q;
  assign cfg_error            = cfg_error_q;
  assign issued_count         = issued_q;

endmodule
